// File: rtl/div_modes_pkg.sv
// Shared types for the RV32M iterative divider: operation codes, FSM states
// and the iteration-counter width helper.
package div_modes_pkg;

   typedef enum logic [1:0] {
      DIVC  = 2'b00,
      DIVUC = 2'b01,
      REMC  = 2'b10,
      REMUC = 2'b11
   } div_code_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_e;

   localparam int unsigned DIV_W     = 32;
   localparam int unsigned DIV_CNT_W = $clog2(DIV_W + 1);

   // Counter must be able to represent 0..dataW.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract step of the divider.
module div_step #(
   parameter int unsigned dataW = 32
) (
   input  logic [dataW-1:0] rem_i,
   input  logic [dataW-1:0] d_i,
   input  logic             bit_i,
   output logic [dataW-1:0] rem_o,
   output logic             qbit_o
);

   logic [dataW:0] shifted_s;

   // The partial remainder stays below the divisor, so the difference always
   // fits in dataW bits even when the shifted value overflows into bit dataW.
   always_comb begin
      shifted_s = {rem_i, bit_i};
      if (shifted_s >= {1'b0, d_i}) begin
         qbit_o = 1'b1;
         rem_o  = shifted_s[dataW-1:0] - d_i;
      end else begin
         qbit_o = 1'b0;
         rem_o  = shifted_s[dataW-1:0];
      end
   end

endmodule

// File: rtl/div_r32m.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one restoring step per clock.
// Define DIV_SPECIAL_EARLY_EN to finish divide-by-zero and overflow at accept.
module div_r32m
   import div_modes_pkg::*;
#(
   parameter int unsigned dataW = 32
) (
   input  logic             clk,
   input  logic             nReset,
   input  logic             start,
   input  div_code_e        divCode,
   input  logic [dataW-1:0] N,
   input  logic [dataW-1:0] D,
   output logic             ready,
   output logic             valid,
   output logic [dataW-1:0] out
);

   localparam int unsigned     cntW     = cnt_width(dataW);
   localparam logic [cntW-1:0] lastCnt  = cntW'(dataW - 1);
   localparam logic [dataW-1:0] zeroW   = {dataW{1'b0}};
   localparam logic [dataW-1:0] onesW   = {dataW{1'b1}};
   localparam logic [dataW-1:0] minNeg  = {1'b1, {(dataW-1){1'b0}}};

   div_state_e       state_q;
   logic [cntW-1:0]  cnt_q;
   logic             ready_q;
   logic             valid_q;
   logic [dataW-1:0] out_q;
   logic [dataW-1:0] rem_q;
   logic [dataW-1:0] quo_q;
   logic [dataW-1:0] dvs_q;
   logic             neg_q_q;
   logic             neg_r_q;
   logic             rem_sel_q;
   logic             spec_q;
   logic [dataW-1:0] spec_val_q;

   logic             is_signed_s;
   logic             is_rem_s;
   logic             n_neg_s;
   logic             d_neg_s;
   logic [dataW-1:0] n_abs_s;
   logic [dataW-1:0] d_abs_s;
   logic             d_zero_s;
   logic             ovf_s;
   logic             special_s;
   logic [dataW-1:0] spec_val_s;

   logic [dataW-1:0] rem_d;
   logic             qbit_s;
   logic [dataW-1:0] quo_d;
   logic [dataW-1:0] res_s;

   div_step #(.dataW(dataW)) u_step (
      .rem_i  (rem_q),
      .d_i    (dvs_q),
      .bit_i  (quo_q[dataW-1]),
      .rem_o  (rem_d),
      .qbit_o (qbit_s)
   );

   // Operand decode at the accept boundary: magnitudes, signs and special results.
   always_comb begin
      is_signed_s = (divCode == DIVC) || (divCode == REMC);
      is_rem_s    = (divCode == REMC) || (divCode == REMUC);
      n_neg_s     = is_signed_s && N[dataW-1];
      d_neg_s     = is_signed_s && D[dataW-1];
      n_abs_s     = n_neg_s ? (zeroW - N) : N;
      d_abs_s     = d_neg_s ? (zeroW - D) : D;
      d_zero_s    = (D == zeroW);
      ovf_s       = is_signed_s && (N == minNeg) && (D == onesW);
      special_s   = d_zero_s || ovf_s;
      if (d_zero_s) begin
         spec_val_s = is_rem_s ? N : onesW;
      end else if (ovf_s) begin
         spec_val_s = is_rem_s ? zeroW : N;
      end else begin
         spec_val_s = zeroW;
      end
   end

   // Final-step result with sign correction; special cases override it.
   always_comb begin
      quo_d = {quo_q[dataW-2:0], qbit_s};
      if (spec_q) begin
         res_s = spec_val_q;
      end else if (rem_sel_q) begin
         res_s = neg_r_q ? (zeroW - rem_d) : rem_d;
      end else begin
         res_s = neg_q_q ? (zeroW - quo_d) : quo_d;
      end
   end

   // Control FSM and datapath registers; all outputs are registered.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q    <= IDLE;
         cnt_q      <= {cntW{1'b0}};
         ready_q    <= 1'b1;
         valid_q    <= 1'b0;
         out_q      <= zeroW;
         rem_q      <= zeroW;
         quo_q      <= zeroW;
         dvs_q      <= zeroW;
         neg_q_q    <= 1'b0;
         neg_r_q    <= 1'b0;
         rem_sel_q  <= 1'b0;
         spec_q     <= 1'b0;
         spec_val_q <= zeroW;
      end else begin
         case (state_q)
            IDLE: begin
               valid_q <= 1'b0;
               cnt_q   <= {cntW{1'b0}};
               if (start) begin
                  rem_q      <= zeroW;
                  quo_q      <= n_abs_s;
                  dvs_q      <= d_abs_s;
                  neg_q_q    <= n_neg_s ^ d_neg_s;
                  neg_r_q    <= n_neg_s;
                  rem_sel_q  <= is_rem_s;
                  spec_q     <= special_s;
                  spec_val_q <= spec_val_s;
                  ready_q    <= 1'b0;
`ifdef DIV_SPECIAL_EARLY_EN
                  if (special_s) begin
                     state_q <= DONE;
                     out_q   <= spec_val_s;
                     valid_q <= 1'b1;
                  end else begin
                     state_q <= CALC;
                  end
`else
                  state_q <= CALC;
`endif
               end else begin
                  ready_q <= 1'b1;
               end
            end
            CALC: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               if (cnt_q == lastCnt) begin
                  state_q <= DONE;
                  cnt_q   <= {cntW{1'b0}};
                  out_q   <= res_s;
                  valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + {{(cntW-1){1'b0}}, 1'b1};
               end
            end
            DONE: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= {cntW{1'b0}};
               valid_q <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign ready = ready_q;
   assign valid = valid_q;
   assign out   = out_q;

endmodule

// File: tb/tb_div_r32m.sv
// Scoreboard bench for div_r32m: directed vectors, back-to-back and reset abort.
module tb_div_r32m;
   import div_modes_pkg::*;

   logic        clk;
   logic        nReset;
   logic        start;
   div_code_e   divCode;
   logic [31:0] N;
   logic [31:0] D;
   logic        ready;
   logic        valid;
   logic [31:0] out;

`ifdef DIV_SPECIAL_EARLY_EN
   localparam int SPEC_LAT = 1;
`else
   localparam int SPEC_LAT = 33;
`endif
   localparam int NORM_LAT = 33;

   typedef struct {
      logic [31:0] val;
      int          t;
      int          lat;
      string       nm;
   } exp_t;

   exp_t        sb[$];
   int          cyc;
   int          n_checks;
   int          n_fail;
   bit          hold_pend;
   logic [31:0] hold_val;

   div_r32m #(.dataW(32)) dut (
      .clk     (clk),
      .nReset  (nReset),
      .start   (start),
      .divCode (divCode),
      .N       (N),
      .D       (D),
      .ready   (ready),
      .valid   (valid),
      .out     (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_ready(input string nm);
      int w;
      w = 0;
      @(negedge clk);
      while (!ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_ready_timeout: got ready=0 expected ready=1", nm);
      end
   endtask

   task automatic issue(input div_code_e c, input logic [31:0] n, input logic [31:0] d,
                        input logic [31:0] e, input bit sp, input string nm);
      wait_ready(nm);
      start   = 1'b1;
      divCode = c;
      N       = n;
      D       = d;
      sb.push_back('{e, cyc, sp ? SPEC_LAT : NORM_LAT, nm});
      @(negedge clk);
      start   = 1'b0;
      N       = ~n;
      D       = d + 32'd1;
      divCode = (c == DIVC) ? REMUC : DIVC;
      check({nm, "_busy"}, {31'd0, ready}, 32'd0);
   endtask

   task automatic b2b_one(input div_code_e c, input logic [31:0] n, input logic [31:0] d,
                          input logic [31:0] e, input string nm);
      wait_ready(nm);
      divCode = c;
      N       = n;
      D       = d;
      sb.push_back('{e, cyc, NORM_LAT, nm});
      @(negedge clk);
      N       = 32'hA5A5_A5A5;
      D       = 32'h0000_0003;
      divCode = REMC;
   endtask

   task automatic drain(input string nm);
      int w;
      w = 0;
      while (sb.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_drain: got %0d pending expected 0", nm, sb.size());
         sb.delete();
      end
   endtask

   // Monitor: pop an expectation for every valid pulse, check value, latency and hold.
   initial begin
      exp_t e;
      hold_pend = 1'b0;
      hold_val  = 32'd0;
      forever begin
         @(negedge clk);
         if (!nReset) begin
            hold_pend = 1'b0;
         end else begin
            if (hold_pend) begin
               check("out_hold", out, hold_val);
               hold_pend = 1'b0;
            end
            if (valid) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_valid: got valid=1 out=%h expected no valid", out);
               end else begin
                  e = sb.pop_front();
                  check(e.nm, out, e.val);
                  check({e.nm, "_lat"}, 32'(cyc - e.t), 32'(e.lat));
                  hold_pend = 1'b1;
                  hold_val  = e.val;
               end
            end
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      nReset   = 1'b0;
      start    = 1'b0;
      divCode  = DIVC;
      N        = 32'd0;
      D        = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_out", out, 32'd0);
      nReset = 1'b1;

      issue(DIVUC, 32'd100,       32'd7,       32'd14,        1'b0, "divu_100_7");
      issue(REMUC, 32'd100,       32'd7,       32'd2,         1'b0, "remu_100_7");
      issue(REMC,  32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 1'b0, "rem_m7_2");
      issue(DIVC,  32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 1'b0, "div_m7_2");
      issue(DIVC,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, "div_7_m2");
      issue(REMC,  32'd7,         32'hFFFF_FFFE, 32'd1,       1'b0, "rem_7_m2");
      issue(DIVC,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,       1'b0, "div_m7_m2");
      issue(REMC,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, "rem_m7_m2");
      issue(DIVC,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf");
      issue(REMC,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       1'b1, "rem_ovf");
      issue(DIVUC, 32'h0000_1234, 32'd0,       32'hFFFF_FFFF, 1'b1, "divu_by0");
      issue(REMUC, 32'h0000_1234, 32'd0,       32'h0000_1234, 1'b1, "remu_by0");
      issue(DIVC,  32'h0000_1234, 32'd0,       32'hFFFF_FFFF, 1'b1, "div_by0");
      issue(REMC,  32'hFFFF_FFFB, 32'd0,       32'hFFFF_FFFB, 1'b1, "rem_m5_by0");
      issue(DIVC,  32'h8000_0000, 32'd1,       32'h8000_0000, 1'b0, "div_min_1");
      issue(REMC,  32'h8000_0000, 32'd1,       32'd0,         1'b0, "rem_min_1");
      issue(DIVUC, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       1'b0, "divu_big");
      issue(REMUC, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "remu_big");
      issue(DIVUC, 32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFF, 1'b0, "divu_max_1");
      issue(DIVUC, 32'hDEAD_BEEF, 32'h10,      32'h0DEA_DBEE, 1'b0, "divu_dead");
      issue(REMUC, 32'hDEAD_BEEF, 32'h10,      32'h0000_000F, 1'b0, "remu_dead");
      issue(DIVUC, 32'd5,         32'd9,       32'd0,         1'b0, "divu_5_9");
      issue(REMUC, 32'd5,         32'd9,       32'd5,         1'b0, "remu_5_9");
      drain("directed");

      // Start held high: each op accepted in the IDLE cycle after the previous DONE.
      start = 1'b1;
      b2b_one(DIVUC, 32'd1000,      32'd10, 32'd100,       "b2b_divu");
      b2b_one(REMC,  32'hFFFF_FF9C, 32'd7,  32'hFFFF_FFFE, "b2b_rem");
      b2b_one(DIVC,  32'hFFFF_FF9C, 32'd7,  32'hFFFF_FFF2, "b2b_div");
      start = 1'b0;
      drain("b2b");

      // Reset in the middle of a calculation must abort without a valid pulse.
      wait_ready("abort");
      start   = 1'b1;
      divCode = DIVUC;
      N       = 32'd1000;
      D       = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      nReset = 1'b0;
      @(negedge clk);
      check("abort_ready", {31'd0, ready}, 32'd1);
      check("abort_valid", {31'd0, valid}, 32'd0);
      check("abort_out", out, 32'd0);
      nReset = 1'b1;
      repeat (40) @(negedge clk);
      issue(DIVUC, 32'd1000, 32'd3, 32'd333, 1'b0, "post_abort_div");
      issue(REMUC, 32'd1000, 32'd3, 32'd1,   1'b0, "post_abort_rem");
      drain("post_abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
